multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles a memory request waits for ready before trap; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr  in  32  instruction word from instruction memory, sampled when imem_rdy=1 in FETCH.
REQ-006 SHALL have port imem_req / imem_rdy  out/in  1/1  instruction-fetch request and completion.
REQ-007 SHALL have port dmem_req / dmem_rdy  out/in  1/1  data-access request and completion.
REQ-008 SHALL have port zero  in  1  ALU zero flag from the datapath, valid in EXEC.
REQ-009 SHALL have ports irwe, pcwe, pcsel, regwe, dmemwe, rs2sel, regsel  out  1 each. irwe loads IR; pcwe writes PC; pcsel=1 selects branch target, 0 selects PC+4; regwe writes rd; dmemwe marks a store; rs2sel=1 selects immediate; regsel=1 selects memory data for writeback.
REQ-010 SHALL have port ALUControl  out  4  ALU operation code.
REQ-011 SHALL have ports halted  out  1, err  out  2, and instret  out  CNT_W. err encoding: 00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 IDLE SHALL drive all strobes to 0 and go to FETCH on the next edge.
REQ-014 FETCH SHALL assert imem_req. When imem_rdy=1 it SHALL pulse irwe for that cycle, latch instr internally, and go to DECODE.
REQ-015 DECODE SHALL classify the latched opcode: 0110011 R, 0010011 I-ALU, 0000011 LW (funct3=010 only), 0100011 SW (funct3=010 only), 1100011 BEQ/BNE (funct3 000/001 only). Any other opcode/funct3 SHALL go to HALT with err=01. Legal instructions SHALL go to EXEC.
REQ-016 ALUControl SHALL equal {funct7[5],funct3} for R-type. For I-ALU it SHALL be {funct7[5],funct3} when funct3=101, else {0,funct3}. It SHALL be 0000 for LW/SW and 1000 for branches. It SHALL hold its value from EXEC through WB or MEM.
REQ-017 rs2sel SHALL be 1 for I-ALU, LW and SW in EXEC/MEM/WB, and 0 otherwise. regsel SHALL be 1 only for LW in WB.
REQ-018 From EXEC: R and I-ALU SHALL go to WB; LW and SW SHALL go to MEM. Branches SHALL assert pcwe with pcsel = zero XOR funct3[0], increment instret, and go to FETCH.
REQ-019 MEM SHALL assert dmem_req, plus dmemwe for SW, until dmem_rdy=1. Then LW SHALL go to WB; SW SHALL assert pcwe (pcsel=0), increment instret, and go to FETCH.
REQ-020 WB SHALL assert regwe and pcwe (pcsel=0) for exactly one cycle, increment instret, and go to FETCH.
REQ-021 A wait counter SHALL clear on entering FETCH/MEM and increment each cycle that rdy=0. When it reaches TIMEOUT_CYCLES, the block SHALL go to HALT with err=10 (FETCH) or 11 (MEM), and the request SHALL drop.
REQ-022 HALT SHALL drive all strobes and requests to 0 and assert halted=1. It SHALL be exited only by reset.
REQ-023 rdy inputs SHALL be ignored outside their request state. rdy=1 in the same cycle the request is first asserted SHALL complete the access with zero wait.
REQ-024 instret SHALL wrap from 2^CNT_W-1 to 0 without error.
REQ-025 Each strobe SHALL be high for at most one cycle per instruction, except requests and dmemwe, which SHALL be held until rdy or timeout.

Reset
REQ-026 Reset assertion SHALL immediately force state=IDLE, all outputs 0, err=00, halted=0, instret=0 and wait counter=0, regardless of the current state. This includes mid-MEM with dmemwe high.
REQ-027 The first imem_req SHALL occur one cycle after the first rising edge following reset deassertion.

Structure
REQ-028 Package multi_cycle_pkg SHALL hold the state enum, opcode constants, err codes and ALUControl codes.
REQ-029 The ALUControl/instruction-class decode SHALL be a combinational sub-module alu_decoder. The FSM, wait counter and instret SHALL reside in multi_cycle_control.

Verification
REQ-030 Instruction 0x003100B3 (add x1,x2,x3) with imem_rdy=1 -> irwe in cycle 0, ALUControl=0000 in EXEC, regwe=pcwe=1 in cycle 3 only, instret=1.
REQ-031 Instruction 0x0020A223 (sw) with dmem_rdy delayed 3 cycles -> dmem_req=dmemwe=1 for 4 cycles, then pcwe=1, regwe never 1, instret=1.
REQ-032 Instruction 0x00208463 (beq) with zero=1 -> pcwe=1, pcsel=1 in EXEC. The same instruction with zero=0 -> pcsel=0.
REQ-033 imem_rdy held 0 with TIMEOUT_CYCLES=16 -> halted=1 and err=10 after 16 cycles. No further requests until reset.
REQ-034 Instruction 0xFFFFFFFF -> halted=1, err=01, no regwe/pcwe pulse.
REQ-035 Reset asserted during MEM of a sw -> dmemwe and dmem_req go to 0 before the next clock edge. After release: IDLE, then FETCH.

Source files
------------

// File: rtl/multi_cycle_pkg.sv
// ----------------------------------------------------------------------------
// multi_cycle_pkg
// Shared types and constants for the multi-cycle RV32 control unit:
//   - state_e : controller FSM states
//   - cls_e   : instruction class produced by the decoder
//   - dec_t   : decoder result bundle (class + ALU operation)
//   - opcode / funct3 constants, err codes, ALUControl codes
// ----------------------------------------------------------------------------
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILL = 3'd0,
    CLS_R   = 3'd1,
    CLS_I   = 3'd2,
    CLS_LW  = 3'd3,
    CLS_SW  = 3'd4,
    CLS_BR  = 3'd5
  } cls_e;

  // Opcodes
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // funct3 values that matter to the controller
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;  // SRLI/SRAI: funct7[5] picks arith

  // err encoding
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_IMEM = 2'b10;
  localparam logic [1:0] ERR_DMEM = 2'b11;

  // ALUControl codes with a fixed meaning (others come from {funct7[5],funct3})
  localparam logic [3:0] ALU_ADD = 4'b0000;  // address generation for LW/SW
  localparam logic [3:0] ALU_SUB = 4'b1000;  // branch compare

  typedef struct packed {
    cls_e       cls;
    logic [3:0] aluctl;
  } dec_t;

  function automatic logic [3:0] alu_code(input logic f7b5, input logic [2:0] f3);
    return {f7b5, f3};
  endfunction

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Purely combinational classifier for the latched instruction fields.
// Ports:
//   opcode   in  7  instruction[6:0]
//   funct3   in  3  instruction[14:12]
//   funct7b5 in  1  instruction[30]
//   dec      out    {instruction class, ALUControl}
// Anything not in the supported subset reports CLS_ILL.
// ----------------------------------------------------------------------------
module alu_decoder
  import multi_cycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CLS_ILL, aluctl: ALU_ADD};
    case (opcode)
      OP_R: begin
        dec.cls    = CLS_R;
        dec.aluctl = alu_code(funct7b5, funct3);
      end
      OP_I: begin
        dec.cls = CLS_I;
        // funct7[5] is immediate data for every I-ALU op except the right
        // shifts, where it distinguishes SRAI from SRLI.
        dec.aluctl = (funct3 == F3_SR) ? alu_code(funct7b5, funct3)
                                       : alu_code(1'b0, funct3);
      end
      OP_LW: if (funct3 == F3_WORD) dec.cls = CLS_LW;
      OP_SW: if (funct3 == F3_WORD) dec.cls = CLS_SW;
      OP_BR: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          dec.cls    = CLS_BR;
          dec.aluctl = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// ----------------------------------------------------------------------------
// multi_cycle_control
// Multi-cycle controller for an RV32 subset (R, I-ALU, LW, SW, BEQ/BNE).
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Memory waits are bounded by TIMEOUT_CYCLES; timeouts and illegal
// instructions park the FSM in HALT until reset.
//
// Parameters:
//   TIMEOUT_CYCLES  max wait cycles on imem/dmem ready (1..255)
//   CNT_W           width of the retired-instruction counter
// Ports:
//   clk, reset           clock, async active-high reset
//   instr                instruction word, sampled in FETCH when imem_rdy=1
//   imem_req/imem_rdy    fetch handshake
//   dmem_req/dmem_rdy    data handshake; dmemwe qualifies a store
//   zero                 ALU zero flag (used in EXEC for branches)
//   irwe,pcwe,pcsel,regwe,rs2sel,regsel   datapath strobes / selects
//   ALUControl           ALU operation
//   halted, err          halt indication and cause
//   instret              retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  output logic             imem_req,
  input  logic             imem_rdy,
  output logic             dmem_req,
  input  logic             dmem_rdy,
  input  logic             zero,
  output logic             irwe,
  output logic             pcwe,
  output logic             pcsel,
  output logic             regwe,
  output logic             dmemwe,
  output logic             rs2sel,
  output logic             regsel,
  output logic [3:0]       ALUControl,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);

  // Last wait-count value before a timeout fires.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state, nxt;
  logic [6:0] ir_op;
  logic [2:0] ir_f3;
  logic       ir_f7b5;
  dec_t       dec;
  logic [7:0] wait_cnt;
  logic       in_req, rdy, tmo, retire, post_dec;

  // Register numbers and immediates are consumed by the datapath's own IR.
  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_dec (
    .opcode   (ir_op),
    .funct3   (ir_f3),
    .funct7b5 (ir_f7b5),
    .dec      (dec)
  );

  // Handshake view: rdy only means something in the matching request state.
  assign in_req   = (state == ST_FETCH) || (state == ST_MEM);
  assign rdy      = (state == ST_FETCH) ? imem_rdy : dmem_rdy;
  assign tmo      = in_req && !rdy && (wait_cnt == TMO_LAST);
  assign post_dec = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

  assign retire = ((state == ST_EXEC) && (dec.cls == CLS_BR)) ||
                  ((state == ST_MEM)  && (dec.cls == CLS_SW) && dmem_rdy) ||
                  (state == ST_WB);

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_rdy) nxt = ST_DECODE;
        else if (tmo) nxt = ST_HALT;
      end
      ST_DECODE: nxt = (dec.cls == CLS_ILL) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (dec.cls)
          CLS_BR:         nxt = ST_FETCH;
          CLS_LW, CLS_SW: nxt = ST_MEM;
          default:        nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_rdy) nxt = (dec.cls == CLS_LW) ? ST_WB : ST_FETCH;
        else if (tmo) nxt = ST_HALT;
      end
      ST_WB:     nxt = ST_FETCH;
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state (plus rdy/zero), so an async reset into
  // IDLE drops every strobe without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req   = (state == ST_FETCH);
    irwe       = (state == ST_FETCH) && imem_rdy;
    dmem_req   = (state == ST_MEM);
    dmemwe     = (state == ST_MEM) && (dec.cls == CLS_SW);
    regwe      = (state == ST_WB);
    regsel     = (state == ST_WB) && (dec.cls == CLS_LW);
    pcwe       = retire;
    // Only a taken branch selects the target: BEQ takes on zero, BNE on !zero.
    pcsel      = (state == ST_EXEC) && (dec.cls == CLS_BR) && (zero ^ ir_f3[0]);
    rs2sel     = post_dec &&
                 ((dec.cls == CLS_I) || (dec.cls == CLS_LW) || (dec.cls == CLS_SW));
    ALUControl = post_dec ? dec.aluctl : 4'b0000;
    halted     = (state == ST_HALT);
  end

  // --------------------------------------------------------------------------
  // State, latched IR fields, wait counter, err, instret
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ir_op    <= '0;
      ir_f3    <= '0;
      ir_f7b5  <= 1'b0;
      wait_cnt <= '0;
      err      <= ERR_NONE;
      instret  <= '0;
    end else begin
      state <= nxt;
      if (irwe) begin
        ir_op   <= instr[6:0];
        ir_f3   <= instr[14:12];
        ir_f7b5 <= instr[30];
      end
      // Counts stalled cycles; any other cycle (including the one before a
      // request state is entered) clears it.
      wait_cnt <= (in_req && !rdy) ? wait_cnt + 8'd1 : 8'd0;
      if (nxt == ST_HALT && state != ST_HALT) begin
        case (state)
          ST_DECODE: err <= ERR_ILL;
          ST_FETCH:  err <= ERR_IMEM;
          default:   err <= ERR_DMEM;
        endcase
      end
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// ----------------------------------------------------------------------------
// tb_multi_cycle_control
// Directed bench for multi_cycle_control. Inputs change 2 time units after a
// rising edge; outputs are checked at least 1 unit after any input change,
// always well before the next edge. CNT_W=2 so instret wrap is reachable.
// ----------------------------------------------------------------------------
module tb_multi_cycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        imem_req, imem_rdy, dmem_req, dmem_rdy, zero;
  logic        irwe, pcwe, pcsel, regwe, dmemwe, rs2sel, regsel, halted;
  logic [3:0]  ALUControl;
  logic [1:0]  err;
  logic [1:0]  instret;

  int ncmp = 0;
  int nbad = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LW   = 32'h0000A083;  // lw x1,0(x1)
  localparam logic [31:0] I_SRAI = 32'h4010D093;  // srai x1,x1,1
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  multi_cycle_control #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .imem_req(imem_req), .imem_rdy(imem_rdy),
    .dmem_req(dmem_req), .dmem_rdy(dmem_rdy), .zero(zero),
    .irwe(irwe), .pcwe(pcwe), .pcsel(pcsel), .regwe(regwe), .dmemwe(dmemwe),
    .rs2sel(rs2sel), .regsel(regsel), .ALUControl(ALUControl),
    .halted(halted), .err(err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Entered in FETCH; completes the fetch with zero wait, returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr    = w;
    imem_rdy = 1'b1;
    #1;
    chk("fetch_irwe", irwe, 1);
    chk("fetch_req", imem_req, 1);
    nxt();
    imem_rdy = 1'b0;
    #1;
    chk("decode_irwe", irwe, 0);
    chk("decode_pcwe", pcwe, 0);
  endtask

  initial begin
    reset = 1'b1; instr = '0; imem_rdy = 0; dmem_rdy = 0; zero = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",     {imem_req, dmem_req, dmemwe}, 0);
    chk("rst_strobes", {irwe, pcwe, pcsel, regwe, rs2sel, regsel}, 0);
    chk("rst_alu",     ALUControl, 0);
    chk("rst_halted",  halted, 0);
    chk("rst_err",     err, 0);
    chk("rst_instret", instret, 0);

    reset = 1'b0;
    #1 chk("idle_req", imem_req, 0);
    nxt();
    chk("first_fetch_req", imem_req, 1);

    // ---- add: WB three cycles after the fetch cycle
    fetch(I_ADD);
    nxt();
    chk("add_exec_alu", ALUControl, 4'h0);
    chk("add_exec_rs2sel", rs2sel, 0);
    chk("add_exec_regwe", regwe, 0);
    nxt();
    chk("add_wb_regwe", regwe, 1);
    chk("add_wb_pcwe", pcwe, 1);
    chk("add_wb_pcsel", pcsel, 0);
    chk("add_wb_regsel", regsel, 0);
    nxt();
    chk("add_after_regwe", {regwe, pcwe}, 0);
    chk("add_instret", instret, 1);

    // ---- sw: ready after 3 stall cycles
    fetch(I_SW);
    nxt();
    chk("sw_exec_rs2sel", rs2sel, 1);
    chk("sw_exec_dreq", dmem_req, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("sw_mem_wait_req", {dmem_req, dmemwe}, 2'b11);
      chk("sw_mem_wait_pcwe", pcwe, 0);
    end
    nxt();
    dmem_rdy = 1'b1;
    #1;
    chk("sw_mem_rdy_req", {dmem_req, dmemwe}, 2'b11);
    chk("sw_mem_rdy_pcwe", pcwe, 1);
    chk("sw_mem_rdy_pcsel", pcsel, 0);
    chk("sw_regwe", regwe, 0);
    nxt();
    dmem_rdy = 1'b0;
    #1;
    chk("sw_done_req", {dmem_req, dmemwe, pcwe, regwe}, 0);
    chk("sw_instret", instret, 2);
    chk("sw_next_fetch", imem_req, 1);

    // ---- beq taken
    fetch(I_BEQ);
    nxt();
    zero = 1'b1;
    #1;
    chk("beq_z1_pcwe", pcwe, 1);
    chk("beq_z1_pcsel", pcsel, 1);
    chk("beq_alu", ALUControl, 4'h8);
    nxt();
    zero = 1'b0;
    #1;
    chk("beq_z1_instret", instret, 3);
    chk("beq_z1_after", {pcwe, regwe}, 0);

    // ---- beq not taken; instret wraps 3 -> 0
    fetch(I_BEQ);
    nxt();
    #1;
    chk("beq_z0_pcwe", pcwe, 1);
    chk("beq_z0_pcsel", pcsel, 0);
    nxt();
    chk("instret_wrap", instret, 0);
    chk("beq_z0_fetch", imem_req, 1);

    // ---- lw with zero-wait dmem
    fetch(I_LW);
    nxt();
    chk("lw_exec_rs2sel", rs2sel, 1);
    chk("lw_exec_alu", ALUControl, 4'h0);
    nxt();
    dmem_rdy = 1'b1;
    #1;
    chk("lw_mem_req", {dmem_req, dmemwe}, 2'b10);
    chk("lw_mem_pcwe", pcwe, 0);
    nxt();
    dmem_rdy = 1'b0;
    #1;
    chk("lw_wb", {regwe, pcwe, regsel, rs2sel}, 4'b1111);
    chk("lw_wb_dreq", dmem_req, 0);
    nxt();
    chk("lw_instret", instret, 1);
    chk("lw_after_regsel", regsel, 0);

    // ---- srai: funct7[5] kept for funct3=101
    fetch(I_SRAI);
    nxt();
    chk("srai_exec_alu", ALUControl, 4'hD);
    chk("srai_exec_rs2sel", rs2sel, 1);
    nxt();
    chk("srai_wb_alu_hold", ALUControl, 4'hD);
    chk("srai_wb_regwe", regwe, 1);
    nxt();
    chk("srai_instret", instret, 2);

    // ---- reset in the middle of a store's MEM phase
    fetch(I_SW);
    nxt();
    nxt();
    #1 chk("rstmem_pre", {dmem_req, dmemwe}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("rstmem_drop", {dmem_req, dmemwe}, 0);
    chk("rstmem_instret", instret, 0);
    chk("rstmem_imem", imem_req, 0);
    nxt();
    reset = 1'b0;
    #1 chk("rstmem_idle", imem_req, 0);
    nxt();
    chk("rstmem_fetch", imem_req, 1);

    // ---- illegal instruction
    fetch(I_BAD);
    chk("ill_decode_regwe", regwe, 0);
    nxt();
    chk("ill_halted", halted, 1);
    chk("ill_err", err, 2'b01);
    chk("ill_strobes", {pcwe, regwe, imem_req, dmem_req}, 0);
    nxt();
    chk("ill_stay", halted, 1);

    // ---- imem timeout
    reset = 1'b1;
    #1 chk("rst_clears_halt", {halted, err}, 0);
    nxt();
    reset = 1'b0;
    nxt();
    chk("tmo_i_req1", imem_req, 1);
    repeat (15) nxt();
    chk("tmo_i_req16", imem_req, 1);
    chk("tmo_i_not_yet", halted, 0);
    nxt();
    chk("tmo_i_halted", halted, 1);
    chk("tmo_i_err", err, 2'b10);
    chk("tmo_i_drop", imem_req, 0);
    imem_rdy = 1'b1;
    repeat (3) nxt();
    chk("tmo_i_no_req", {imem_req, irwe}, 0);
    chk("tmo_i_stay", halted, 1);
    imem_rdy = 1'b0;

    // ---- dmem timeout on a store
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    nxt();
    fetch(I_SW);
    nxt();
    nxt();
    chk("tmo_d_req1", {dmem_req, dmemwe}, 2'b11);
    repeat (15) nxt();
    chk("tmo_d_req16", {dmem_req, dmemwe}, 2'b11);
    chk("tmo_d_not_yet", halted, 0);
    nxt();
    chk("tmo_d_halted", halted, 1);
    chk("tmo_d_err", err, 2'b11);
    chk("tmo_d_drop", {dmem_req, dmemwe, pcwe}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
